// File: rtl/scan_reg_bank.sv
// scan_reg_bank: WIDTH functional flops split into NUM_CHAINS scan chains of
// length L, with functional capture, manual shift, an optional shadow stage
// that keeps q stable while shifting, and an auto-shift sequencer that
// performs exactly L shifts per request.
module scan_reg_bank #(
  parameter int                 WIDTH      = 8,
  parameter int                 NUM_CHAINS = 2,
  parameter bit                 SHADOW     = 1'b1,
  parameter logic [WIDTH-1:0]   RESET_VAL  = '0,
  localparam int                L          = WIDTH / NUM_CHAINS,
  localparam int                CW         = $clog2(L + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      d,
  input  logic                  func_en,
  input  logic                  scan_en,
  input  logic [NUM_CHAINS-1:0] scan_in,
  output logic [NUM_CHAINS-1:0] scan_out,
  input  logic                  update_en,
  input  logic                  auto_start,
  output logic                  auto_busy,
  output logic                  auto_done,
  output logic [CW-1:0]         shift_cnt,
  output logic [WIDTH-1:0]      q,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [CW-1:0]     r_cnt;
  logic [CW-1:0]     w_cnt_next;
  logic              r_busy;
  logic              r_done;
  logic [WIDTH-1:0]  r_cap;
  logic [WIDTH-1:0]  w_shifted;
  logic              w_shifting;

  // A manual shift and a sequencer shift look identical to the chains.
  assign w_shifting = scan_en | r_busy;

  // Shifted image of the capture register: each chain moves toward its
  // low bit, taking scan_in[c] at its top bit.
  always_comb begin
    w_shifted = r_cap;
    for (int c = 0; c < NUM_CHAINS; c++) begin
      for (int i = 0; i < L - 1; i++) begin
        w_shifted[c*L + i] = r_cap[c*L + i + 1];
      end
      w_shifted[c*L + L - 1] = scan_in[c];
    end
  end

  // Serial outputs come straight from the lowest flop of each chain.
  always_comb begin
    scan_out = '0;
    for (int c = 0; c < NUM_CHAINS; c++) begin
      scan_out[c] = r_cap[c*L];
    end
  end

  // Capture register: shift beats functional capture, otherwise hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cap <= RESET_VAL;
    end else if (w_shifting) begin
      r_cap <= w_shifted;
    end else if (func_en) begin
      r_cap <= d;
    end
  end

  // Sequencer state, count and registered status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      r_busy  <= (w_next == ST_SHIFT);
      r_done  <= (w_next == ST_DONE);
    end
  end

  // Sequencer next state: L shifts, then a single DONE cycle.
  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (auto_start) begin
          w_next     = ST_SHIFT;
          w_cnt_next = CW'(L);
        end
      end
      ST_SHIFT: begin
        if (r_cnt == CW'(1)) begin
          w_next     = ST_DONE;
          w_cnt_next = '0;
        end else begin
          w_cnt_next = r_cnt - CW'(1);
        end
      end
      ST_DONE: begin
        w_next = ST_IDLE;
      end
      default: begin
        w_next     = ST_IDLE;
        w_cnt_next = '0;
      end
    endcase
  end

  assign auto_busy = r_busy;
  assign auto_done = r_done;
  assign shift_cnt = r_cnt;
  assign dbg_state = r_state;

  if (SHADOW) begin : g_shadow
    logic [WIDTH-1:0] r_shadow;

    // Shadow follows the capture register on request when not shifting,
    // and automatically once an auto shift has completed.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_shadow <= RESET_VAL;
      end else if ((r_state == ST_DONE) || (update_en && !w_shifting)) begin
        r_shadow <= r_cap;
      end
    end

    assign q = r_shadow;
  end else begin : g_direct
    logic w_unused_update;
    assign w_unused_update = update_en;
    assign q = r_cap;
  end

endmodule

// File: tb/tb_scan_reg_bank.sv
// Directed bench for scan_reg_bank: default shadowed build (L=4), a
// SHADOW=0 build and an L=1 build, all sharing clk and rst.
module tb_scan_reg_bank;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  // Main DUT: WIDTH=8, NUM_CHAINS=2, SHADOW=1
  logic [7:0] d = '0;
  logic       func_en = 0, scan_en = 0, update_en = 0, auto_start = 0;
  logic [1:0] scan_in = '0;
  logic [1:0] scan_out;
  logic       auto_busy, auto_done;
  logic [2:0] shift_cnt;
  logic [7:0] q;
  logic [1:0] dbg_state;

  // SHADOW=0 DUT
  logic [7:0] d0 = '0;
  logic       func_en0 = 0, scan_en0 = 0;
  logic [1:0] scan_in0 = '0;
  logic [1:0] scan_out0;
  logic       auto_busy0, auto_done0;
  logic [2:0] shift_cnt0;
  logic [7:0] q0;
  logic [1:0] dbg_state0;

  // L=1 DUT: WIDTH=2, NUM_CHAINS=2
  logic [1:0] scan_in1 = '0;
  logic       auto_start1 = 0;
  logic [1:0] scan_out1;
  logic       auto_busy1, auto_done1;
  logic [0:0] shift_cnt1;
  logic [1:0] q1;
  logic [1:0] dbg_state1;

  int n_assert = 0;
  int n_fail   = 0;
  logic [1:0] exp_so [4];

  scan_reg_bank #(.WIDTH(8), .NUM_CHAINS(2), .SHADOW(1'b1), .RESET_VAL(8'h00)) u_dut (
    .clk(clk), .rst(rst), .d(d), .func_en(func_en), .scan_en(scan_en),
    .scan_in(scan_in), .scan_out(scan_out), .update_en(update_en),
    .auto_start(auto_start), .auto_busy(auto_busy), .auto_done(auto_done),
    .shift_cnt(shift_cnt), .q(q), .dbg_state(dbg_state)
  );

  scan_reg_bank #(.WIDTH(8), .NUM_CHAINS(2), .SHADOW(1'b0), .RESET_VAL(8'h00)) u_dut0 (
    .clk(clk), .rst(rst), .d(d0), .func_en(func_en0), .scan_en(scan_en0),
    .scan_in(scan_in0), .scan_out(scan_out0), .update_en(1'b1),
    .auto_start(1'b0), .auto_busy(auto_busy0), .auto_done(auto_done0),
    .shift_cnt(shift_cnt0), .q(q0), .dbg_state(dbg_state0)
  );

  scan_reg_bank #(.WIDTH(2), .NUM_CHAINS(2), .SHADOW(1'b1), .RESET_VAL(2'b00)) u_dut1 (
    .clk(clk), .rst(rst), .d(2'b00), .func_en(1'b0), .scan_en(1'b0),
    .scan_in(scan_in1), .scan_out(scan_out1), .update_en(1'b0),
    .auto_start(auto_start1), .auto_busy(auto_busy1), .auto_done(auto_done1),
    .shift_cnt(shift_cnt1), .q(q1), .dbg_state(dbg_state1)
  );

  // Clock
  always #5 clk = ~clk;

  // Advance one rising edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  initial begin
    // 1. Reset, capture, update
    tick(); tick();
    rst = 1'b0;
    chk("rst_q", 32'(q), 32'h00);
    chk("rst_scan_out", 32'(scan_out), 32'h0);
    chk("rst_busy", 32'(auto_busy), 32'h0);
    chk("rst_done", 32'(auto_done), 32'h0);
    chk("rst_cnt", 32'(shift_cnt), 32'h0);
    chk("rst_state", 32'(dbg_state), 32'h0);

    d = 8'hA5; func_en = 1'b1; tick(); func_en = 1'b0;
    chk("cap_q_held", 32'(q), 32'h00);
    chk("cap_scan_out", 32'(scan_out), 32'h1);
    update_en = 1'b1; tick(); update_en = 1'b0;
    chk("upd_q", 32'(q), 32'hA5);

    // 2. Manual shift of 0xA5 with scan_in=11
    exp_so[0] = 2'b01; exp_so[1] = 2'b10; exp_so[2] = 2'b01; exp_so[3] = 2'b10;
    scan_in = 2'b11; scan_en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("man_so%0d", k), 32'(scan_out), 32'(exp_so[k]));
      chk($sformatf("man_q%0d", k), 32'(q), 32'hA5);
      tick();
    end
    scan_en = 1'b0;
    chk("man_so_end", 32'(scan_out), 32'h3);
    update_en = 1'b1; tick(); update_en = 1'b0;
    chk("man_q_ff", 32'(q), 32'hFF);

    // 3. Auto shift with scan_in=01, extra auto_start mid-shift
    scan_in = 2'b01; auto_start = 1'b1; tick(); auto_start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("auto_busy%0d", k), 32'(auto_busy), 32'h1);
      chk($sformatf("auto_cnt%0d", k), 32'(shift_cnt), 32'(4 - k));
      chk($sformatf("auto_done_lo%0d", k), 32'(auto_done), 32'h0);
      chk($sformatf("auto_q%0d", k), 32'(q), 32'hFF);
      if (k == 1) auto_start = 1'b1;
      tick();
      auto_start = 1'b0;
    end
    chk("auto_done_pulse", 32'(auto_done), 32'h1);
    chk("auto_busy_off", 32'(auto_busy), 32'h0);
    chk("auto_cnt_zero", 32'(shift_cnt), 32'h0);
    tick();
    chk("auto_done_clear", 32'(auto_done), 32'h0);
    chk("auto_no_ext", 32'(auto_busy), 32'h0);
    chk("auto_idle", 32'(dbg_state), 32'h0);
    chk("auto_q", 32'(q), 32'h0F);

    // 4. Priority: shift beats func_en
    scan_in = 2'b00; scan_en = 1'b1; func_en = 1'b1; d = 8'h00; tick();
    scan_en = 1'b0; func_en = 1'b0;
    chk("prio_scan_out", 32'(scan_out), 32'h1);
    update_en = 1'b1; tick(); update_en = 1'b0;
    chk("prio_q", 32'(q), 32'h07);

    // update_en during auto_busy is ignored
    auto_start = 1'b1; tick(); auto_start = 1'b0;
    update_en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("busy_upd_q%0d", k), 32'(q), 32'h07);
    end
    update_en = 1'b0;
    chk("busy_upd_done", 32'(auto_done), 32'h1);
    tick();
    chk("busy_upd_final", 32'(q), 32'h00);

    // 5. Asynchronous reset mid-shift
    d = 8'hFF; func_en = 1'b1; tick(); func_en = 1'b0;
    update_en = 1'b1; tick(); update_en = 1'b0;
    chk("pre_rst_q", 32'(q), 32'hFF);
    scan_in = 2'b11; auto_start = 1'b1; tick(); auto_start = 1'b0;
    tick(); tick();
    chk("pre_rst_cnt", 32'(shift_cnt), 32'h2);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(auto_busy), 32'h0);
    chk("mid_rst_cnt", 32'(shift_cnt), 32'h0);
    chk("mid_rst_q", 32'(q), 32'h00);
    chk("mid_rst_so", 32'(scan_out), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    chk("post_rst_state", 32'(dbg_state), 32'h0);
    auto_start = 1'b1; tick(); auto_start = 1'b0;
    chk("restart_busy", 32'(auto_busy), 32'h1);
    chk("restart_cnt", 32'(shift_cnt), 32'h4);
    for (int k = 0; k < 4; k++) tick();
    chk("restart_done", 32'(auto_done), 32'h1);
    tick();
    chk("restart_q", 32'(q), 32'hFF);

    // update_en with func_en loads the pre-capture value
    d = 8'h5A; func_en = 1'b1; update_en = 1'b1; tick();
    func_en = 1'b0;
    chk("upd_cap_old", 32'(q), 32'hFF);
    tick(); update_en = 1'b0;
    chk("upd_cap_new", 32'(q), 32'h5A);

    // 6. SHADOW=0 build
    d0 = 8'h3C; func_en0 = 1'b1; tick(); func_en0 = 1'b0;
    chk("nosh_cap", 32'(q0), 32'h3C);
    scan_in0 = 2'b10; scan_en0 = 1'b1; tick();
    chk("nosh_shift1", 32'(q0), 32'h96);
    tick(); scan_en0 = 1'b0;
    chk("nosh_shift2", 32'(q0), 32'hC3);

    // L=1 build: one SHIFT cycle then DONE
    scan_in1 = 2'b10; auto_start1 = 1'b1; tick(); auto_start1 = 1'b0;
    chk("l1_busy", 32'(auto_busy1), 32'h1);
    chk("l1_cnt", 32'(shift_cnt1), 32'h1);
    tick();
    chk("l1_done", 32'(auto_done1), 32'h1);
    chk("l1_busy_off", 32'(auto_busy1), 32'h0);
    chk("l1_so", 32'(scan_out1), 32'h2);
    tick();
    chk("l1_q", 32'(q1), 32'h2);
    chk("l1_done_clear", 32'(auto_done1), 32'h0);

    // Final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
